// File: rtl/delayed_branch_resolver_pkg.sv
// Shared CPU definitions: condition codes, instruction heads, resolver FSM states.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package delayed_branch_resolver_pkg;

    // Condition codes carried alongside each delayed instruction.
    typedef enum logic [2:0] {
        COND_NV = 3'd0,
        COND_AL = 3'd1,
        COND_EQ = 3'd2,
        COND_NE = 3'd3,
        COND_LT = 3'd4,
        COND_LE = 3'd5,
        COND_GT = 3'd6,
        COND_GE = 3'd7
    } cond_t;

    // Instruction heads (IR[15:8]).
    localparam logic [7:0] HEAD_DEFAULT = 8'h20;
    localparam logic [7:0] HEAD_HALT    = 8'h27;

    // Resolver control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRE  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One pipeline slot: the delayed instruction and its condition.
    typedef struct packed {
        logic [15:0] ir;
        cond_t       cond;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{ir: 16'h0000, cond: COND_NV};

endpackage

// File: rtl/delayed_branch_resolver_if.sv
// Bundle between the fetch/branch generator and the delayed branch resolver.
// Wires only, no latency.
// Flow is paced by advance, which both sides share as the pipeline step.
interface delayed_branch_resolver_if;

    logic        advance;
    logic [15:0] p0_delayed_B_1in;
    logic [15:0] p1_delayed_B_1in;
    logic [2:0]  p0_delayed_cond_1in;
    logic [2:0]  p1_delayed_cond_1in;
    logic        N;
    logic        V;
    logic        Z;
    logic        p0_do_delayed_B;
    logic        p1_do_delayed_B;
    logic [15:0] delayed_IR_out;
    logic        flush;
    logic [15:0] taken_count;

    // Fetch side: supplies delayed instructions and flags, receives reinjection.
    modport master (
        output advance, p0_delayed_B_1in, p1_delayed_B_1in,
               p0_delayed_cond_1in, p1_delayed_cond_1in, N, V, Z,
        input  p0_do_delayed_B, p1_do_delayed_B, delayed_IR_out, flush, taken_count
    );

    // Resolver side.
    modport slave (
        input  advance, p0_delayed_B_1in, p1_delayed_B_1in,
               p0_delayed_cond_1in, p1_delayed_cond_1in, N, V, Z,
        output p0_do_delayed_B, p1_do_delayed_B, delayed_IR_out, flush, taken_count
    );

endinterface

// File: rtl/delayed_branch_resolver_cond_eval.sv
// Evaluates one condition code against the N/V/Z flags.
// Purely combinational, zero latency.
// No flow control; result is consumed by the resolver when advance is high.
module cond_eval
    import delayed_branch_resolver_pkg::*;
(
    input  cond_t cond,
    input  logic  n,
    input  logic  v,
    input  logic  z,
    output logic  taken
);

    logic lt;

    assign lt = n ^ v;

    // Decode the condition into a single taken bit.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NV: taken = 1'b0;
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_LT: taken = lt;
            COND_LE: taken = z | lt;
            COND_GT: taken = !z & !lt;
            COND_GE: taken = !lt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/delayed_branch_resolver.sv
// Resolves delayed branches in two lanes after a two-stage delay and reinjects the winner.
// Latency: input sampled into S2, shifted to S3, resolved on the following advancing edge.
// Backpressure: advance=0 freezes every stage, the FSM and the pending strobe.
module delayed_branch_resolver
    import delayed_branch_resolver_pkg::*;
(
    input  logic clk,
    input  logic rst,
    delayed_branch_resolver_if.slave bus
);

    slot_t       p0_s2, p0_s3, p1_s2, p1_s3;
    slot_t       p0_s2_nxt, p0_s3_nxt, p1_s2_nxt, p1_s3_nxt;
    slot_t       p0_in, p1_in;
    state_t      state, state_nxt;
    logic        p0_take, p1_take;
    logic        p0_do, p1_do, flush_q;
    logic        p0_do_nxt, p1_do_nxt, flush_nxt;
    logic [15:0] ir_q, ir_nxt;
    logic [15:0] taken_cnt, taken_cnt_nxt;

    cond_eval u_p0_eval (
        .cond  (p0_s3.cond),
        .n     (bus.N),
        .v     (bus.V),
        .z     (bus.Z),
        .taken (p0_take)
    );

    cond_eval u_p1_eval (
        .cond  (p1_s3.cond),
        .n     (bus.N),
        .v     (bus.V),
        .z     (bus.Z),
        .taken (p1_take)
    );

    // Next-state, pipeline shift and registered-output logic; p0 is older so it wins.
    always_comb begin
        state_nxt     = state;
        p0_s2_nxt     = p0_s2;
        p0_s3_nxt     = p0_s3;
        p1_s2_nxt     = p1_s2;
        p1_s3_nxt     = p1_s3;
        p0_do_nxt     = p0_do;
        p1_do_nxt     = p1_do;
        flush_nxt     = flush_q;
        ir_nxt        = ir_q;
        taken_cnt_nxt = taken_cnt;
        p0_in         = SLOT_EMPTY;
        p1_in         = SLOT_EMPTY;

        // Anything fetched while a redirect is in flight is wrong-path: capture as empty.
        if (state == IDLE) begin
            p0_in = '{ir: bus.p0_delayed_B_1in, cond: cond_t'(bus.p0_delayed_cond_1in)};
            p1_in = '{ir: bus.p1_delayed_B_1in, cond: cond_t'(bus.p1_delayed_cond_1in)};
        end

        if (bus.advance) begin
            p0_s2_nxt = p0_in;
            p0_s3_nxt = p0_s2;
            p1_s2_nxt = p1_in;
            p1_s3_nxt = p1_s2;

            case (state)
                IDLE: begin
                    if (p0_take || p1_take) begin
                        state_nxt = FIRE;
                        p0_do_nxt = p0_take;
                        p1_do_nxt = !p0_take;
                        flush_nxt = 1'b1;
                        ir_nxt    = p0_take ? p0_s3.ir : p1_s3.ir;
                        // Everything younger than the taken branch is killed.
                        p0_s2_nxt = SLOT_EMPTY;
                        p0_s3_nxt = SLOT_EMPTY;
                        p1_s2_nxt = SLOT_EMPTY;
                        p1_s3_nxt = SLOT_EMPTY;
                        if (taken_cnt != 16'hFFFF)
                            taken_cnt_nxt = taken_cnt + 16'd1;
                    end
                end
                FIRE: begin
                    // Strobe consumed by the generator on this advancing edge.
                    state_nxt = DRAIN;
                    p0_do_nxt = 1'b0;
                    p1_do_nxt = 1'b0;
                    flush_nxt = 1'b0;
                    ir_nxt    = 16'h0000;
                end
                DRAIN: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, pipeline and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            p0_s2     <= SLOT_EMPTY;
            p0_s3     <= SLOT_EMPTY;
            p1_s2     <= SLOT_EMPTY;
            p1_s3     <= SLOT_EMPTY;
            p0_do     <= 1'b0;
            p1_do     <= 1'b0;
            flush_q   <= 1'b0;
            ir_q      <= 16'h0000;
            taken_cnt <= 16'h0000;
        end else begin
            state     <= state_nxt;
            p0_s2     <= p0_s2_nxt;
            p0_s3     <= p0_s3_nxt;
            p1_s2     <= p1_s2_nxt;
            p1_s3     <= p1_s3_nxt;
            p0_do     <= p0_do_nxt;
            p1_do     <= p1_do_nxt;
            flush_q   <= flush_nxt;
            ir_q      <= ir_nxt;
            taken_cnt <= taken_cnt_nxt;
        end
    end

    assign bus.p0_do_delayed_B = p0_do;
    assign bus.p1_do_delayed_B = p1_do;
    assign bus.flush           = flush_q;
    assign bus.delayed_IR_out  = ir_q;
    assign bus.taken_count     = taken_cnt;

endmodule

// File: tb/tb_delayed_branch_resolver.sv
// Directed bench for the delayed branch resolver.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each scenario task checks its own expectations inline.
module tb_delayed_branch_resolver;
    import delayed_branch_resolver_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    delayed_branch_resolver_if bus ();

    delayed_branch_resolver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {cond[2:0], N, V, Z, expected_taken}
    localparam logic [6:0] VEC [16] = '{
        {3'd5, 1'b1, 1'b0, 1'b0, 1'b1},  // LE, N^V
        {3'd5, 1'b0, 1'b0, 1'b0, 1'b0},  // LE, nothing set
        {3'd5, 1'b0, 1'b0, 1'b1, 1'b1},  // LE, Z
        {3'd6, 1'b0, 1'b0, 1'b0, 1'b1},  // GT
        {3'd6, 1'b0, 1'b0, 1'b1, 1'b0},  // GT, Z kills it
        {3'd6, 1'b1, 1'b1, 1'b0, 1'b1},  // GT, N==V
        {3'd6, 1'b1, 1'b0, 1'b0, 1'b0},  // GT, N^V kills it
        {3'd7, 1'b1, 1'b1, 1'b0, 1'b1},  // GE
        {3'd7, 1'b0, 1'b1, 1'b0, 1'b0},  // GE, N^V
        {3'd4, 1'b0, 1'b1, 1'b0, 1'b1},  // LT
        {3'd4, 1'b1, 1'b1, 1'b0, 1'b0},  // LT, N==V
        {3'd3, 1'b0, 1'b0, 1'b0, 1'b1},  // NE
        {3'd3, 1'b0, 1'b0, 1'b1, 1'b0},  // NE, Z
        {3'd2, 1'b1, 1'b1, 1'b0, 1'b0},  // EQ, !Z
        {3'd0, 1'b1, 1'b1, 1'b1, 1'b0},  // NV never fires
        {3'd1, 1'b0, 1'b0, 1'b0, 1'b1}   // AL always fires
    };

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [15:0] b0, input logic [2:0] c0,
                          input logic [15:0] b1, input logic [2:0] c1);
        bus.p0_delayed_B_1in    = b0;
        bus.p0_delayed_cond_1in = c0;
        bus.p1_delayed_B_1in    = b1;
        bus.p1_delayed_cond_1in = c1;
    endtask

    task automatic clear_in();
        set_in(16'h0000, 3'd0, 16'h0000, 3'd0);
    endtask

    task automatic set_flags(input logic n, input logic v, input logic z);
        bus.N = n;
        bus.V = v;
        bus.Z = z;
    endtask

    // Single p0 AL branch with advance held: load, shift, fire, then FIRE->DRAIN->IDLE.
    task automatic al_fire(input logic [15:0] ir);
        bus.advance = 1'b1;
        set_in(ir, 3'd1, 16'h0000, 3'd0);
        step();
        clear_in();
        step();
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.advance = 1'b0;
        clear_in();
        set_flags(1'b0, 1'b0, 1'b0);
        step();
        step();
        tests_run++;
        if ({bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b expected 000",
                     {bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush});
        end
        tests_run++;
        if (bus.delayed_IR_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_ir: got %h expected 0000", bus.delayed_IR_out);
        end
        tests_run++;
        if (bus.taken_count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_count: got %h expected 0000", bus.taken_count);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_eq_taken();
        set_flags(1'b0, 1'b0, 1'b1);
        bus.advance = 1'b1;
        set_in(16'h2015, 3'd2, 16'h0000, 3'd0);
        step();
        clear_in();
        tests_run++;
        if (bus.p0_do_delayed_B !== 1'b0) begin
            tests_failed++;
            $display("FAIL eq_early_s2: got %b expected 0", bus.p0_do_delayed_B);
        end
        step();
        tests_run++;
        if (bus.p0_do_delayed_B !== 1'b0) begin
            tests_failed++;
            $display("FAIL eq_early_s3: got %b expected 0", bus.p0_do_delayed_B);
        end
        step();
        tests_run++;
        if ({bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush} !== 3'b101) begin
            tests_failed++;
            $display("FAIL eq_strobes: got %b expected 101",
                     {bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush});
        end
        tests_run++;
        if (bus.delayed_IR_out !== 16'h2015) begin
            tests_failed++;
            $display("FAIL eq_ir: got %h expected 2015", bus.delayed_IR_out);
        end
        tests_run++;
        if (bus.taken_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL eq_count: got %0d expected 1", bus.taken_count);
        end
        step();
        tests_run++;
        if ({bus.p0_do_delayed_B, bus.flush, bus.delayed_IR_out} !== 18'h0) begin
            tests_failed++;
            $display("FAIL eq_pulse_end: got %b/%b/%h expected 0/0/0000",
                     bus.p0_do_delayed_B, bus.flush, bus.delayed_IR_out);
        end
        step();
    endtask

    task automatic test_p1_fire();
        set_flags(1'b0, 1'b0, 1'b0);
        bus.advance = 1'b1;
        set_in(16'h2015, 3'd2, 16'h2030, 3'd1);
        step();
        clear_in();
        step();
        step();
        tests_run++;
        if ({bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush} !== 3'b011) begin
            tests_failed++;
            $display("FAIL p1_strobes: got %b expected 011",
                     {bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush});
        end
        tests_run++;
        if (bus.delayed_IR_out !== 16'h2030) begin
            tests_failed++;
            $display("FAIL p1_ir: got %h expected 2030", bus.delayed_IR_out);
        end
        tests_run++;
        if (bus.taken_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL p1_count: got %0d expected 2", bus.taken_count);
        end
        step();
        step();
    endtask

    task automatic test_both_al();
        int strobes;
        bus.advance = 1'b1;
        set_in(16'h2040, 3'd1, 16'h2050, 3'd1);
        step();
        set_in(16'h2060, 3'd1, 16'h0000, 3'd0);
        step();
        clear_in();
        step();
        tests_run++;
        if ({bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush} !== 3'b101) begin
            tests_failed++;
            $display("FAIL both_strobes: got %b expected 101",
                     {bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush});
        end
        tests_run++;
        if (bus.delayed_IR_out !== 16'h2040) begin
            tests_failed++;
            $display("FAIL both_ir: got %h expected 2040", bus.delayed_IR_out);
        end
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.p0_do_delayed_B !== 1'b0 || bus.p1_do_delayed_B !== 1'b0)
                strobes++;
        end
        tests_run++;
        if (strobes != 0) begin
            tests_failed++;
            $display("FAIL both_dropped: got %0d strobe cycles expected 0", strobes);
        end
        tests_run++;
        if (bus.taken_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL both_count: got %0d expected 3", bus.taken_count);
        end
    endtask

    task automatic test_halt_stall();
        int strobes;
        bus.advance = 1'b1;
        set_in(16'h2712, 3'd1, 16'h0000, 3'd0);
        step();
        clear_in();
        bus.advance = 1'b0;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.p0_do_delayed_B !== 1'b0) strobes++;
        end
        bus.advance = 1'b1;
        step();
        if (bus.p0_do_delayed_B !== 1'b0) strobes++;
        tests_run++;
        if (strobes != 0) begin
            tests_failed++;
            $display("FAIL halt_stalled: got %0d strobe cycles expected 0", strobes);
        end
        step();
        tests_run++;
        if ({bus.p0_do_delayed_B, bus.delayed_IR_out} !== {1'b1, 16'h2712}) begin
            tests_failed++;
            $display("FAIL halt_fire: got %b/%h expected 1/2712",
                     bus.p0_do_delayed_B, bus.delayed_IR_out);
        end
        bus.advance = 1'b0;
        step();
        step();
        tests_run++;
        if ({bus.p0_do_delayed_B, bus.flush, bus.delayed_IR_out} !== {2'b11, 16'h2712}) begin
            tests_failed++;
            $display("FAIL halt_hold: got %b/%b/%h expected 1/1/2712",
                     bus.p0_do_delayed_B, bus.flush, bus.delayed_IR_out);
        end
        bus.advance = 1'b1;
        step();
        tests_run++;
        if ({bus.p0_do_delayed_B, bus.flush} !== 2'b00) begin
            tests_failed++;
            $display("FAIL halt_consumed: got %b expected 00",
                     {bus.p0_do_delayed_B, bus.flush});
        end
        tests_run++;
        if (bus.taken_count !== 16'd4) begin
            tests_failed++;
            $display("FAIL halt_count: got %0d expected 4", bus.taken_count);
        end
        step();
    endtask

    task automatic test_cond_table();
        logic [6:0]  v;
        logic [15:0] ir;
        logic [18:0] want;
        logic [18:0] got;
        bus.advance = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v  = VEC[i];
            ir = 16'h2000 + 16'(i);
            set_flags(v[3], v[2], v[1]);
            set_in(ir, v[6:4], 16'h0000, 3'd0);
            step();
            clear_in();
            step();
            step();
            want = v[0] ? {3'b101, ir} : 19'h0;
            got  = {bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush, bus.delayed_IR_out};
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL cond_vec%0d: got %h expected %h", i, got, want);
            end
            step();
            step();
        end
    endtask

    task automatic test_reset_mid_fire();
        int strobes;
        set_flags(1'b0, 1'b0, 1'b0);
        bus.advance = 1'b1;
        set_in(16'h2080, 3'd1, 16'h0000, 3'd0);
        step();
        clear_in();
        step();
        step();
        tests_run++;
        if (bus.p0_do_delayed_B !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstfire_armed: got %b expected 1", bus.p0_do_delayed_B);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush,
             bus.delayed_IR_out, bus.taken_count} !== 35'h0) begin
            tests_failed++;
            $display("FAIL rstfire_outputs: got %b%b%b/%h/%h expected all 0",
                     bus.p0_do_delayed_B, bus.p1_do_delayed_B, bus.flush,
                     bus.delayed_IR_out, bus.taken_count);
        end
        tests_run++;
        if (dut.state !== IDLE) begin
            tests_failed++;
            $display("FAIL rstfire_state: got %0d expected %0d", dut.state, IDLE);
        end
        step();
        rst = 1'b1;
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.p0_do_delayed_B !== 1'b0 || bus.p1_do_delayed_B !== 1'b0) strobes++;
        end
        tests_run++;
        if (strobes != 0) begin
            tests_failed++;
            $display("FAIL rstfire_no_reinject: got %0d strobe cycles expected 0", strobes);
        end
    endtask

    task automatic test_saturation();
        // Start the counter just below its ceiling.
        force dut.taken_cnt = 16'hFFFC;
        step();
        release dut.taken_cnt;
        al_fire(16'h2001);
        tests_run++;
        if (bus.taken_count !== 16'hFFFD) begin
            tests_failed++;
            $display("FAIL sat_step: got %h expected fffd", bus.taken_count);
        end
        al_fire(16'h2002);
        al_fire(16'h2003);
        tests_run++;
        if (bus.taken_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_reach: got %h expected ffff", bus.taken_count);
        end
        al_fire(16'h2004);
        al_fire(16'h2005);
        al_fire(16'h2006);
        tests_run++;
        if (bus.taken_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_hold: got %h expected ffff", bus.taken_count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_eq_taken();
        test_p1_fire();
        test_both_al();
        test_halt_stall();
        test_cond_table();
        test_reset_mid_fire();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
